// File: rtl/uart_tx_engine.sv
// uart_tx_engine: 8N1 UART transmitter with a one-entry holding register and sticky overrun flag.
// Ports: PCLK / PRESETn (async, active-low) clock and reset; tx_en_i enables frame start;
//   hs_mode_i selects one baud tick per bit; uart_run_flag_i rising edge accepts write_data_i;
//   cd_i is PCLK cycles per baud tick (0 acts as 1); err_clr_i clears error_tx_detect_o;
//   TXD_o serial line (idle high); TXdone_o pulses in the last cycle of the stop bit;
//   tx_busy_o shifter active; tx_buffer_full_o holding register occupied; error_tx_detect_o overrun.
module uart_tx_engine #(
    parameter int DATA_W     = 8,
    parameter int CD_W       = 13,
    parameter int OVERSAMPLE = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              tx_en_i,
    input  logic              hs_mode_i,
    input  logic              uart_run_flag_i,
    input  logic [DATA_W-1:0] write_data_i,
    input  logic [CD_W-1:0]   cd_i,
    input  logic              err_clr_i,
    output logic              TXD_o,
    output logic              TXdone_o,
    output logic              tx_busy_o,
    output logic              tx_buffer_full_o,
    output logic              error_tx_detect_o
);
    localparam int SW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [SW-1:0] SMAX = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BLAST = BW'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q, state_d;
    logic [CD_W-1:0]   cd_q, cd_d, tick_q, tick_d;
    logic [SW-1:0]     samp_q, samp_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d, hold_q, hold_d;
    logic              hs_q, hs_d, full_q, full_d, err_q, err_d, txd_q, txd_d, done_q, done_d, run_q;
    logic              accept, load, tick_last, bit_end;

    assign accept    = uart_run_flag_i & ~run_q;
    assign tick_last = tick_q == cd_q - CD_W'(1);
    assign bit_end   = tick_last & (samp_q == (hs_q ? '0 : SMAX));
    // A waiting byte is picked up from IDLE or straight out of the last stop cycle (no idle gap).
    assign load      = full_q & tx_en_i & ((state_q == IDLE) | ((state_q == STOP) & bit_end));

    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        hs_d    = hs_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        txd_d   = txd_q;
        tick_d  = '0;
        samp_d  = '0;
        hold_d  = hold_q;
        full_d  = full_q & ~load;
        // The byte being loaded frees the holder this cycle, so a coincident accept is not an overrun.
        if (accept && (!full_q || load)) begin
            hold_d = write_data_i;
            full_d = 1'b1;
        end
        err_d = (err_q & ~err_clr_i) | (accept & full_q & ~load);
        if (state_q != IDLE && !bit_end) begin
            tick_d = tick_last ? '0 : tick_q + CD_W'(1);
            samp_d = tick_last ? samp_q + SW'(1) : samp_q;
        end
        if (load) begin
            state_d = START;
            shift_d = hold_q;
            cd_d    = (cd_i == '0) ? CD_W'(1) : cd_i;
            hs_d    = hs_mode_i;
            txd_d   = 1'b0;
        end else if (bit_end) begin
            case (state_q)
                START: begin
                    state_d = DATA;
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                end
                DATA: begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + BW'(1);
                    state_d = (bit_q == BLAST) ? STOP : DATA;
                    txd_d   = (bit_q == BLAST) ? 1'b1 : shift_d[0];
                end
                STOP: begin
                    state_d = IDLE;
                    txd_d   = 1'b1;
                end
                default: ;
            endcase
        end
        // Registered TXdone: flag the cycle whose next-state counters sit on the stop bit's last tick.
        done_d = (state_d == STOP) & (tick_d == cd_d - CD_W'(1)) & (samp_d == (hs_d ? '0 : SMAX));
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            cd_q    <= '0;
            hs_q    <= 1'b0;
            tick_q  <= '0;
            samp_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            hold_q  <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            txd_q   <= 1'b1;
            done_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
            hs_q    <= hs_d;
            tick_q  <= tick_d;
            samp_q  <= samp_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
            full_q  <= full_d;
            err_q   <= err_d;
            txd_q   <= txd_d;
            done_q  <= done_d;
            run_q   <= uart_run_flag_i;
        end
    end

    assign TXD_o             = txd_q;
    assign TXdone_o          = done_q;
    assign tx_busy_o         = state_q != IDLE;
    assign tx_buffer_full_o  = full_q;
    assign error_tx_detect_o = err_q;
endmodule
